// File: rtl/pipe_arith_pkg.sv
// Shared definitions for the segmented pipelined adder/subtractor.
// Holds the operation encoding and the segment-geometry helpers.
package pipe_arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic bit stages_ok(input int w, input int s);
        return (s >= 1) && (s <= w) && ((w % s) == 0);
    endfunction

    // Guarded so an illegal STAGES still reaches the elaboration error.
    function automatic int seg_bits(input int w, input int s);
        return (s > 0) ? (w / s) : 1;
    endfunction

endpackage

// File: rtl/pipe_add_seg.sv
// One carry-segment stage: SEG-bit adder, registered sum/carry, valid bit.
// The output stage (LAST) also resets its data so the result port reads 0.
module pipe_add_seg #(
    parameter int SEG  = 8,
    parameter bit LAST = 1'b0
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           en,
    input  logic           flush,
    input  logic           v_in,
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           c_in,
    output logic           v_q,
    output logic [SEG-1:0] s_q,
    output logic           c_q,
    output logic           ovf_q
);

    logic           v_d;
    logic [SEG-1:0] s_nx;
    logic [SEG-1:0] s_d;
    logic           c_nx;
    logic           c_d;
    logic           ovf_nx;
    logic           ovf_d;

    always_comb begin
        {c_nx, s_nx} = {1'b0, a_seg} + {1'b0, b_seg}
                     + {{SEG{1'b0}}, c_in};
        ovf_nx = (a_seg[SEG-1] == b_seg[SEG-1])
              && (s_nx[SEG-1] != a_seg[SEG-1]);
        v_d   = flush ? 1'b0 : (en ? v_in : v_q);
        s_d   = en ? s_nx : s_q;
        c_d   = en ? c_nx : c_q;
        ovf_d = en ? ovf_nx : ovf_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) v_q <= 1'b0;
        else          v_q <= v_d;
    end

    if (LAST) begin : g_rst
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s_q   <= '0;
                c_q   <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                s_q   <= s_d;
                c_q   <= c_d;
                ovf_q <= ovf_d;
            end
        end
    end else begin : g_nrst
        always_ff @(posedge clock) begin
            s_q   <= s_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with one carry segment per stage.
// Global stall on output back-pressure; flush clears all valid bits.
module pipe_addsub
    import pipe_arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int SEG = seg_bits(WIDTH, STAGES);

    if (!stages_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_addsub: STAGES must divide WIDTH, 1..WIDTH");
    end

    op_e              op;
    logic             stall;
    logic             en;
    logic [WIDTH-1:0] a_st   [STAGES];
    logic [WIDTH-1:0] b_st   [STAGES];
    logic [WIDTH-1:0] acc_st [STAGES];
    logic             c_st   [STAGES+1];
    logic             v_st   [STAGES+1];
    logic             ovf_st [STAGES];

    assign op       = op_e'(sub);
    assign stall    = v_st[STAGES] && !out_ready;
    assign en       = !stall;
    assign in_ready = en;

    // Subtract is a + ~b + !borrow, folded in before stage 0.
    assign a_st[0]   = a;
    assign b_st[0]   = (op == OP_SUB) ? ~b : b;
    assign c_st[0]   = (op == OP_SUB) ? ~c_in : c_in;
    assign v_st[0]   = in_valid && in_ready;
    assign acc_st[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam bit LAST = (k == STAGES - 1);

        logic [SEG-1:0]         seg_s;
        logic [(k+1)*SEG-1:0]   acc_nx;

        pipe_add_seg #(
            .SEG  (SEG),
            .LAST (LAST)
        ) u_seg (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (en),
            .flush   (flush),
            .v_in    (v_st[k]),
            .a_seg   (a_st[k][k*SEG +: SEG]),
            .b_seg   (b_st[k][k*SEG +: SEG]),
            .c_in    (c_st[k]),
            .v_q     (v_st[k+1]),
            .s_q     (seg_s),
            .c_q     (c_st[k+1]),
            .ovf_q   (ovf_st[k])
        );

        if (k == 0) begin : g_first
            assign acc_nx = seg_s;
        end else begin : g_lo
            logic [k*SEG-1:0] lo_d;
            logic [k*SEG-1:0] lo_q;

            always_comb lo_d = en ? acc_st[k][k*SEG-1:0] : lo_q;

            if (LAST) begin : g_rst
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) lo_q <= '0;
                    else          lo_q <= lo_d;
                end
            end else begin : g_nrst
                always_ff @(posedge clock) lo_q <= lo_d;
            end

            assign acc_nx = {seg_s, lo_q};
        end

        if (LAST) begin : g_out
            assign sum = acc_nx;
        end else begin : g_fwd
            logic [WIDTH-1:0] a_d;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_d;
            logic [WIDTH-1:0] b_q;

            always_comb begin
                a_d = en ? a_st[k] : a_q;
                b_d = en ? b_st[k] : b_q;
            end

            always_ff @(posedge clock) begin
                a_q <= a_d;
                b_q <= b_d;
            end

            assign a_st[k+1]   = a_q;
            assign b_st[k+1]   = b_q;
            assign acc_st[k+1] = WIDTH'(acc_nx);
        end
    end

    assign out_valid = v_st[STAGES];
    assign c_out     = c_st[STAGES];
    assign ovf       = ovf_st[STAGES-1];

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of carry-segment pipeline stages; legal range 1..WIDTH; WIDTH % STAGES == 0, else elaboration error.
REQ-003 SHALL have port clock, input, 1, sole clock; every register updates on its rising edge only.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand set offered.
REQ-006 SHALL have port in_ready, output, 1, operand set accepted when in_valid && in_ready.
REQ-007 SHALL have ports a and b, input, WIDTH each, operands.
REQ-008 SHALL have port c_in, input, 1, carry-in; in subtract mode it is borrow-in.
REQ-009 SHALL have port sub, input, 1, 0 = add, 1 = subtract; sampled with its operands.
REQ-010 SHALL have port flush, input, 1, synchronous pipeline clear.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have ports sum (WIDTH), c_out (1) and ovf (1), outputs, result, carry-out and signed overflow.

Function
REQ-014 SHALL use SEG = WIDTH/STAGES bit segments; stage k (1..STAGES) adds segment k-1 plus the carry registered by stage k-1.
REQ-015 SHALL compute in add mode {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1).
REQ-016 SHALL compute in subtract mode {c_out,sum} = a + ~b + !c_in, so sum = a - b - c_in and c_out = 1 means no borrow.
REQ-017 SHALL set ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff is b in add mode and ~b in subtract mode.
REQ-018 SHALL present a result on sum/c_out/ovf with out_valid exactly STAGES cycles after acceptance, absent stalls.
REQ-019 SHALL carry a valid bit per stage; unconsumed high segments and sub travel with their operand set.
REQ-020 SHALL stall globally: stall = out_valid && !out_ready; during a stall no stage register changes.
REQ-021 SHALL drive in_ready = !stall combinationally; bubbles are not collapsed.
REQ-022 SHALL sustain one result per cycle when out_ready is held high.
REQ-023 SHALL hold sum/c_out/ovf stable while out_valid && !out_ready.
REQ-024 SHALL, on flush, clear all valid bits at the next edge and accept no input that cycle; flush overrides stall and a simultaneous in_valid.
REQ-025 SHALL carry out of the top segment into c_out only, with no wrap into bit 0.
REQ-026 SHALL produce, when STAGES = 1, a one-cycle registered adder with the same handshake.

Reset
REQ-027 SHALL clear every valid bit and drive sum = 0, c_out = 0, ovf = 0, out_valid = 0 while reset_n is low, independent of clock.
REQ-028 SHALL discard in-flight operand sets when reset asserts mid-operation; no partial result appears after release.
REQ-029 SHALL leave datapath registers other than outputs unreset; only valid bits and outputs are reset.

Structure
REQ-030 SHALL place the legality check on WIDTH/STAGES and the SEG derivation in shared package pipe_arith_pkg.
REQ-031 SHALL implement one segment stage as sub-module pipe_add_seg (SEG-bit adder plus carry register plus valid bit), instantiated STAGES times by generate.
REQ-032 SHALL contain no latches, no negedge logic and no blocking assignments to registers.

Verification
REQ-033 SHALL cover: WIDTH=32, STAGES=4, add a=0xFFFFFFFF, b=0x00000001, c_in=0 -> after 4 cycles sum=0x00000000, c_out=1, ovf=0.
REQ-034 SHALL cover: subtract a=0x80000000, b=0x00000001, c_in=0 -> sum=0x7FFFFFFF, c_out=1, ovf=1.
REQ-035 SHALL cover: 8 back-to-back operand sets with out_ready=1 -> 8 consecutive out_valid cycles in order, no bubbles.
REQ-036 SHALL cover: out_ready=0 for 5 cycles with a full pipeline -> in_ready=0, outputs frozen, then 4 results drain in order with none lost.
REQ-037 SHALL cover: flush with 3 sets in flight and in_valid=1 -> out_valid=0 from the next cycle, that input is not accepted, and none of the 3 emerge.
REQ-038 SHALL cover: reset_n pulsed low between clock edges mid-stream -> outputs 0 immediately, random WIDTH/STAGES (8/2, 64/8, 16/1) checked against a reference model.
